bcd_conv_scheduler: RTL and testbench
=====================================

Name: bcd_conv_scheduler

Overview:
Shared, iterative double-dabble binary-to-BCD engine with a round-robin front end for two requesters. It serialises the conversion to one bit per clock, which avoids a combinational add-3 cascade per requester. Requesters use a valid/ready handshake. Results leave on a single output channel with valid/ready backpressure, tagged with the requester id. Typical clients are display drivers: one for counter readout and one for frequency/measurement readout.

Parameters:
BIN_WIDTH, 14, width of each binary input
NUM_DIGITS, 5, number of BCD digits produced; must satisfy 10^NUM_DIGITS > 2^BIN_WIDTH - 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  2  bit i high: requester i presents data
req_ready  output  2  bit i high: requester i accepted this cycle (combinational, one-hot or zero)
req_data0  input  BIN_WIDTH  binary value, requester 0
req_data1  input  BIN_WIDTH  binary value, requester 1
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_id  output  1  requester that owns the result
out_bcd  output  4*NUM_DIGITS  packed BCD, most significant digit in the top nibble
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE.
  - out_valid=0, out_id=0, out_bcd=0, busy=0, req_ready=0.
  - Round-robin pointer is cleared, so requester 0 has priority.
  - Reset overrides all other inputs. If asserted in SHIFT or DONE, the in-flight conversion is discarded and never reported.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any req_valid bit is high, grant one requester. req_ready for that requester is high in this cycle only.
  - At the edge, the granted data is loaded into the shifter with BCD field cleared, out_id takes the granted index, the iteration counter is set to 0, and state goes to SHIFT.
  - If no req_valid bit is high, stay in IDLE with req_ready=0.
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, grant the one not granted last. Immediately after reset, that is requester 0.
  - The pointer updates only on a grant.
- SHIFT, one iteration per edge:
  - Every BCD nibble whose value is 5 or more has 3 added.
  - Then the whole {bcd, bin} register shifts left by 1.
  - On the BIN_WIDTH-th iteration, state goes to DONE, out_bcd is registered from the BCD field, and out_valid goes to 1.
  - out_valid therefore rises exactly BIN_WIDTH edges after the accepting edge (14 by default).
- DONE:
  - out_valid, out_bcd and out_id are held stable until out_ready is high.
  - On an edge with out_ready high: out_valid goes to 0 and state goes to IDLE.
  - No new grant is issued in DONE, so req_ready=0 throughout SHIFT and DONE.
  - Minimum spacing between accepts is BIN_WIDTH+2 edges.
- Arithmetic:
  - Add-3 is performed per 4-bit nibble without carry into the next nibble; a corrected nibble is at most 12.
  - All digits in out_bcd are 0-9.
  - Leading digits are zero, with no blanking.
- req_data is sampled only at the accepting edge. Later changes to the data or to req_valid have no effect on the conversion in flight.
- out_bcd and out_id keep their last values after the output handshake until the next result is registered.

Test Plan:
1. Reset: assert rst 2 cycles while req_valid=2'b11. Required: out_valid=0, busy=0, req_ready=0 throughout, out_bcd=0 after reset.
2. Single conversion: req_data0=16383, req_valid=01, out_ready=1. Required:
   - req_ready=01 for one cycle.
   - out_valid rises 14 edges later with out_bcd=0x16383 and out_id=0.
   - busy=0 one edge after the output handshake.
3. Arbitration: req_data0=1234, req_data1=9876, both valid continuously. Required: four results with out_id sequence 0,1,0,1 and out_bcd alternating 0x01234 and 0x09876.
4. Backpressure: conversion of 9999 with out_ready=0 for 10 cycles. Required:
   - out_valid stays 1, out_bcd=0x09999 stable.
   - req_ready stays 0 despite req_valid=10.
   - After out_ready=1: one edge to IDLE, then requester 1 is granted.
5. Reset mid-operation: accept 500, assert rst at iteration 6. Required: no out_valid pulse, state IDLE; the next request for 0 yields out_bcd=0x00000 with out_id=0.
6. Boundaries: inputs 0, 9, 10, 99, 100 and 8191. Required: out_bcd of 0x00000, 0x00009, 0x00010, 0x00099, 0x00100 and 0x08191, each exactly 14 edges after its accept.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// Shared iterative double-dabble binary-to-BCD converter with a two-requester
// round-robin front end and a single valid/ready result channel tagged by id.
module bcd_conv_scheduler #(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [BIN_WIDTH-1:0]      req_data0,
    input  logic [BIN_WIDTH-1:0]      req_data1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_id,
    output logic [4*NUM_DIGITS-1:0]   out_bcd,
    output logic                      busy
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [BIN_WIDTH-1:0]   bin_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   prio_q;
    logic                   out_valid_q;
    logic                   out_id_q;
    logic [BCD_W-1:0]       out_bcd_q;

    logic                   grant_any_s;
    logic                   grant_id_s;
    logic [BCD_W-1:0]       bcd_adj_s;
    logic [BCD_W-1:0]       bcd_d;
    logic [BIN_WIDTH-1:0]   bin_d;

    // Nibble correction without carry: 5..9 become 8..12, so the shift yields a valid digit.
    function automatic logic [3:0] dabble_nibble(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Round-robin pick: prio_q names the requester favoured on a tie.
    always_comb begin
        grant_id_s = 1'b0;
        case (req_valid)
            2'b01:   grant_id_s = 1'b0;
            2'b10:   grant_id_s = 1'b1;
            2'b11:   grant_id_s = prio_q;
            default: grant_id_s = 1'b0;
        endcase
    end

    assign grant_any_s = (state_q == IDLE) && (req_valid != 2'b00) && !rst;

    // One-hot acceptance strobe, only ever asserted from IDLE.
    always_comb begin
        req_ready = 2'b00;
        if (grant_any_s) begin
            req_ready = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // One double-dabble iteration: correct every digit, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = dabble_nibble(bcd_q[4*i +: 4]);
        end
        bcd_d = {bcd_adj_s[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
    end

    // Control FSM, shifter and registered result channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any_s) begin
                        bin_q    <= grant_id_s ? req_data1 : req_data0;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        out_id_q <= grant_id_s;
                        prio_q   <= ~grant_id_s;
                        state_q  <= SHIFT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        out_bcd_q   <= bcd_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q     <= SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_bcd   = out_bcd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Self-checking bench for bcd_conv_scheduler: directed sequences, a vector
// table and randomized traffic against a decimal-arithmetic reference model.
module tb_bcd_conv_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [13:0] req_data0;
    logic [13:0] req_data1;
    logic        out_valid;
    logic        out_ready;
    logic        out_id;
    logic [19:0] out_bcd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bcd_conv_scheduler #(.BIN_WIDTH(14), .NUM_DIGITS(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_bcd(out_bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [13:0] data;
        logic [19:0] exp_bcd;
    } vec_t;

    vec_t vecs[9];

    // Reference: decimal digits by repeated division.
    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                g = req_ready;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for the grant, then checks latency, data and id of the result.
    task automatic collect(input logic exp_id, input logic [19:0] exp_bcd,
                           input string name, input bit drop);
        logic [1:0] g;
        int lat;
        wait_grant(g);
        check({name, "_grant"}, g, exp_id ? 2'b10 : 2'b01);
        if (g == 2'b00) return;
        @(posedge clk);
        #1;
        check({name, "_ready_low"}, req_ready, 2'b00);
        if (drop) req_valid = 2'b00;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 40);
        check({name, "_latency"}, lat, 14);
        check({name, "_bcd"}, out_bcd, exp_bcd);
        check({name, "_id"}, out_id, exp_id);
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, out_valid, 1'b0);
        check({name, "_busy_drop"}, busy, 1'b0);
    endtask

    task automatic run_one(input logic id, input logic [13:0] data,
                           input logic [19:0] exp_bcd, input string name);
        if (id) req_data1 = data; else req_data0 = data;
        req_valid = id ? 2'b10 : 2'b01;
        collect(id, exp_bcd, name, 1'b1);
    endtask

    initial begin
        logic [1:0] g;
        int         pref;
        logic [1:0] v;
        logic [13:0] d0, d1;
        logic       eid;

        clk = 1'b0;
        rst = 1'b1;
        req_valid = 2'b11;
        req_data0 = '0;
        req_data1 = '0;
        out_ready = 1'b1;

        vecs[0] = '{1'b0, 14'd0,     20'h00000};
        vecs[1] = '{1'b1, 14'd9,     20'h00009};
        vecs[2] = '{1'b0, 14'd10,    20'h00010};
        vecs[3] = '{1'b1, 14'd99,    20'h00099};
        vecs[4] = '{1'b0, 14'd100,   20'h00100};
        vecs[5] = '{1'b1, 14'd8191,  20'h08191};
        vecs[6] = '{1'b0, 14'd16383, 20'h16383};
        vecs[7] = '{1'b1, 14'd1000,  20'h01000};
        vecs[8] = '{1'b0, 14'd4095,  20'h04095};

        // Reset held with both requesters valid
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_req_ready", req_ready, 2'b00);
        end
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        check("rst_out_bcd", out_bcd, 20'h00000);
        check("rst_out_id", out_id, 1'b0);

        // Single conversion of full-scale value
        @(negedge clk);
        run_one(1'b0, 14'd16383, 20'h16383, "single");

        // Arbitration with both requesters valid continuously
        do_reset();
        req_data0 = 14'd1234;
        req_data1 = 14'd9876;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            collect(1'(k % 2), (k % 2) ? 20'h09876 : 20'h01234, "arb", 1'b0);
        end
        req_valid = 2'b00;

        // Backpressure holds the result and blocks new grants
        do_reset();
        out_ready = 1'b0;
        req_data0 = 14'd9999;
        req_data1 = 14'd42;
        req_valid = 2'b01;
        wait_grant(g);
        check("bp_grant", g, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_bcd_held", out_bcd, 20'h09999);
            check("bp_ready_blocked", req_ready, 2'b00);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle", busy, 1'b0);
        check("bp_next_ready", req_ready, 2'b10);
        collect(1'b1, 20'h00042, "bp_next", 1'b1);

        // Reset during the sixth iteration discards the conversion
        do_reset();
        req_data0 = 14'd500;
        req_valid = 2'b01;
        wait_grant(g);
        check("midrst_grant", g, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_no_valid", out_valid, 1'b0);
            check("midrst_idle", busy, 1'b0);
        end
        run_one(1'b0, 14'd0, 20'h00000, "midrst_next");

        // Boundary and table vectors
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_one(vecs[i].id, vecs[i].data, vecs[i].exp_bcd, "table");
        end

        // Randomized traffic against the arbitration/decimal model
        do_reset();
        pref = 0;
        for (int i = 0; i < 30; i++) begin
            v  = 2'($urandom_range(1, 3));
            d0 = 14'($urandom_range(0, 16383));
            d1 = 14'($urandom_range(0, 16383));
            if (v == 2'b01)      eid = 1'b0;
            else if (v == 2'b10) eid = 1'b1;
            else                 eid = 1'(pref);
            pref = eid ? 0 : 1;
            req_data0 = d0;
            req_data1 = d1;
            req_valid = v;
            collect(eid, to_bcd(eid ? int'(d1) : int'(d0)), "rand", 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
